// File: rtl/mips_pkg.sv
// Shared constants for the MIPS issue controller: instruction field positions,
// opcodes and the issue FSM state type.
package mips_pkg;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;
  localparam int RD_MSB = 15;
  localparam int RD_LSB = 11;

  // ALU register-register ops occupy 000000 up to this opcode
  localparam logic [5:0] OP_ALU_MAX = 6'b000101;
  localparam logic [5:0] OP_LW      = 6'b001000;
  localparam logic [5:0] OP_SW      = 6'b001001;
  localparam logic [5:0] OP_ADDI    = 6'b001010;
  localparam logic [5:0] OP_SUBI    = 6'b001011;
  localparam logic [5:0] OP_SLTI    = 6'b001100;
  localparam logic [5:0] OP_BNEQZ   = 6'b001101;
  localparam logic [5:0] OP_BEQZ    = 6'b001110;
  localparam logic [5:0] OP_HLT     = 6'b111111;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    BR_WAIT = 2'd1,
    DRAIN   = 2'd2,
    HALTED  = 2'd3
  } state_t;

endpackage

// File: rtl/mips_issue_ctrl_if.sv
// ID/EX handshake bundle between the pipeline and the issue controller.
interface mips_issue_ctrl_if;

  logic        id_valid;
  logic [31:0] id_instr;
  logic        br_resolve;
  logic        br_taken;
  logic        issue;
  logic        stall;
  logic        flush;
  logic        halted;
  logic [31:0] wr_pending;

  modport master (
    output id_valid, id_instr, br_resolve, br_taken,
    input  issue, stall, flush, halted, wr_pending
  );

  modport slave (
    input  id_valid, id_instr, br_resolve, br_taken,
    output issue, stall, flush, halted, wr_pending
  );

endinterface

// File: rtl/mips_instr_decode.sv
// Combinational operand/destination decode of the instruction held in ID.
module mips_instr_decode
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  output logic [4:0]  rd_a,
  output logic        rd_a_en,
  output logic [4:0]  rd_b,
  output logic        rd_b_en,
  output logic [4:0]  wr_dst,
  output logic        wr_en,
  output logic        is_branch,
  output logic        is_halt
);

  logic [5:0] op;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       unused_low;

  assign op = instr[OP_MSB:OP_LSB];
  assign rs = instr[RS_MSB:RS_LSB];
  assign rt = instr[RT_MSB:RT_LSB];
  assign rd = instr[RD_MSB:RD_LSB];
  // shamt/funct/immediate bits play no part in hazard detection
  assign unused_low = ^instr[RD_LSB-1:0];

  always_comb begin
    rd_a      = rs;
    rd_b      = rt;
    rd_a_en   = 1'b0;
    rd_b_en   = 1'b0;
    wr_dst    = 5'd0;
    wr_en     = 1'b0;
    is_branch = 1'b0;
    is_halt   = 1'b0;
    if (op <= OP_ALU_MAX) begin
      rd_a_en = 1'b1;
      rd_b_en = 1'b1;
      wr_dst  = rd;
      wr_en   = 1'b1;
    end else begin
      case (op)
        OP_LW, OP_ADDI, OP_SUBI, OP_SLTI: begin
          rd_a_en = 1'b1;
          wr_dst  = rt;
          wr_en   = 1'b1;
        end
        OP_SW: begin
          rd_a_en = 1'b1;
          rd_b_en = 1'b1;
        end
        OP_BNEQZ, OP_BEQZ: begin
          rd_a_en   = 1'b1;
          is_branch = 1'b1;
        end
        OP_HLT:  is_halt = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mips_issue_ctrl.sv
// Issue/hazard controller: RAW interlock via an in-flight write line,
// branch hold until resolution, and drain-then-halt on HLT.
module mips_issue_ctrl
  import mips_pkg::*;
#(
  parameter int WB_LAT = 3
) (
  input logic              clk1,
  input logic              rst,
  mips_issue_ctrl_if.slave bus
);

  logic [4:0] rd_a, rd_b, wr_dst;
  logic       rd_a_en, rd_b_en, wr_en, is_branch, is_halt;

  mips_instr_decode u_dec (
    .instr     (bus.id_instr),
    .rd_a      (rd_a),
    .rd_a_en   (rd_a_en),
    .rd_b      (rd_b),
    .rd_b_en   (rd_b_en),
    .wr_dst    (wr_dst),
    .wr_en     (wr_en),
    .is_branch (is_branch),
    .is_halt   (is_halt)
  );

  state_t      state, state_nxt;
  logic        vld_p [WB_LAT];
  logic [4:0]  dst_p [WB_LAT];
  logic [31:0] pend;
  logic        hazard;
  logic        issue;
  logic        flush;

  always_comb begin
    pend = '0;
    for (int i = 0; i < WB_LAT; i++) begin
      if (vld_p[i]) pend[dst_p[i]] = 1'b1;
    end
  end

  // R0 is never recorded in the line, so pend[0] can never raise a hazard
  assign hazard = (rd_a_en & pend[rd_a]) | (rd_b_en & pend[rd_b]);

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    flush     = 1'b0;
    case (state)
      RUN: begin
        issue = bus.id_valid & ~hazard & ~rst;
        if (issue & is_branch)    state_nxt = BR_WAIT;
        else if (issue & is_halt) state_nxt = DRAIN;
      end
      BR_WAIT: begin
        if (bus.br_resolve) begin
          flush     = bus.br_taken & ~rst;
          state_nxt = RUN;
        end
      end
      DRAIN: begin
        if (pend == '0) state_nxt = HALTED;
      end
      HALTED: ;
    endcase
  end

  assign bus.issue      = issue;
  assign bus.flush      = flush;
  assign bus.stall      = (bus.id_valid & ~issue) | (state != RUN);
  assign bus.halted     = (state == HALTED);
  assign bus.wr_pending = pend;

  // Stage boundary: FSM state and write-line valid bits
  always_ff @(posedge clk1) begin
    if (rst) begin
      state <= RUN;
      for (int i = 0; i < WB_LAT; i++) vld_p[i] <= 1'b0;
    end else begin
      state    <= state_nxt;
      vld_p[0] <= issue & wr_en & (wr_dst != 5'd0);
      for (int i = 1; i < WB_LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // Stage boundary: write-line destinations, qualified by vld_p
  always_ff @(posedge clk1) begin
    dst_p[0] <= wr_dst;
    for (int i = 1; i < WB_LAT; i++) dst_p[i] <= dst_p[i-1];
  end

endmodule

// File: doc/mips_issue_ctrl.md
# mips_issue_ctrl

Issue/hazard controller for the 32-bit MIPS pipeline. It sits between the ID stage and EX and decides each cycle whether the instruction held in ID may advance. It tracks in-flight register writes to interlock RAW hazards, holds issue while a branch resolves, and drains the pipeline on HLT. It replaces hand-inserted dummy instructions in programs.

## Interface
- `WB_LAT`, default 3: cycles a write stays pending after issue (EX, MEM, WB).
- `clk1`  in  1  : single clock, rising edge.
- `rst`  in  1  : synchronous reset, active-high.
- `id_valid`  in  1  : ID holds a valid instruction.
- `id_instr`  in  32  : instruction word in ID.
- `br_resolve`  in  1  : one-cycle pulse from EX when a branch is resolved.
- `br_taken`  in  1  : branch outcome, qualified by `br_resolve`.
- `issue`  out  1  : ID instruction moves to EX at the end of this cycle.
- `stall`  out  1  : IF/ID hold their contents; equals `id_valid & ~issue`, or 1 in BR_WAIT, DRAIN or HALTED.
- `flush`  out  1  : kill the IF/ID contents this cycle.
- `halted`  out  1  : sticky; set once the pipeline has drained after HLT.
- `wr_pending`  out  32  : bitmap of registers with an in-flight write; bit 0 is always 0.

## Operation
- Decode uses fields op[31:26], rs[25:21], rt[20:16], rd[15:11].
  - ALU RR ops 000000–000101: read rs and rt, write rd.
  - ADDI/SUBI/SLTI 001010–001100 and LW 001000: read rs, write rt.
  - SW 001001: read rs and rt, no write.
  - BNEQZ 001101 and BEQZ 001110: read rs, no write.
  - HLT 111111: no operands.
  - Any other opcode: no reads, no write; it issues as a NOP.
- Register R0 is never a hazard source and is never recorded as a write destination.
- Write tracking: a shift line of `WB_LAT` entries, each holding a valid bit and a 5-bit destination.
  - Every cycle, entry0 is loaded with the destination if `issue` is high and the instruction writes a non-zero register; otherwise entry0 is loaded invalid.
  - The remaining entries shift down by one.
  - `wr_pending` is the OR of the decoded valid entries.
- Hazard: a source register matches any valid entry.
- States:
  - RUN: `issue = id_valid & ~hazard`. If a branch issues, go to BR_WAIT. If HLT issues, go to DRAIN.
  - BR_WAIT: `issue = 0`. On `br_resolve`, `flush = br_taken` in the same cycle, and the state returns to RUN on the next cycle.
  - DRAIN: `issue = 0`. If `wr_pending == 0` in this cycle, go to HALTED.
  - HALTED: `issue = 0` and `halted = 1`. This state exits only on `rst`.
- `br_resolve` received outside BR_WAIT is ignored, and `flush` stays 0.
- `flush` is asserted only in BR_WAIT.

## Timing
- `issue`, `stall` and `flush` are combinational from registered state plus the ID and EX inputs.
- `wr_pending` and `halted` are registered.
- A write issued in cycle t is visible in `wr_pending` during cycles t+1 through t+WB_LAT. A dependent instruction can issue no earlier than cycle t+WB_LAT+1.
- After a branch issues in cycle t, BR_WAIT begins at t+1. The earliest next issue is the cycle after `br_resolve`.
- After HLT issues in cycle t, DRAIN begins at t+1. `halted` rises one cycle after the first DRAIN cycle in which `wr_pending == 0`.
- Reset, including mid-branch or mid-drain, takes effect on the next edge:
  - state goes to RUN;
  - all entries are cleared;
  - `halted = 0`, `wr_pending = 0`.
  - During the cycle `rst` is high, `issue = 0` and `flush = 0`.
- A destination that is still in flight may be re-issued as a new write. Both entries coexist, and the hazard clears only when the later entry retires.

## Structure
- `mips_pkg` holds:
  - the opcode localparams;
  - the state enum (RUN, BR_WAIT, DRAIN, HALTED);
  - the field-position constants.
- The natural sub-module is `mips_instr_decode`, which is combinational. Outputs:
  - `rd_a`, `rd_a_en`
  - `rd_b`, `rd_b_en`
  - `wr_dst`, `wr_en`
  - `is_branch`, `is_halt`
- The top level contains the shift line, the FSM and the output logic.

## Test plan
1. Back-to-back 2801000a (ADDI R1) then 28020014 (ADDI R2) with `id_valid` held high → both issue on consecutive cycles; `wr_pending` = 0x2 and then 0x6.
2. 2801000a issued at cycle t, then 00222000 (ADD R4,R1,R2) → `stall = 1` for cycles t+1 to t+3; `issue = 1` at t+4.
3. 28000005 (ADDI R0) followed by 00002000 (ADD R4,R0,R0) → no stall, and `wr_pending` stays 0.
4. BEQZ 38200004 issued, with a follow-on instruction in ID:
   - no issue until `br_resolve`;
   - with `br_taken = 1`, `flush = 1` in the resolve cycle and the state is RUN on the next cycle;
   - with `br_taken = 0`, there is no flush and the follow-on instruction issues in the next cycle.
5. 28030019 (ADDI R3) issued at cycle t, then fc000000 (HLT) at t+1 → `halted` rises at t+5 and stays high; later `id_valid` pulses produce no issue; `rst` returns the block to RUN with `halted = 0`.
6. Assert `rst` in the cycle after a branch issues → RUN with `wr_pending = 0`; a following instruction issues immediately.
